tlu_dut_rx: RTL and testbench

//  DUT-side end of the TLU trigger handshake: qualifies TLU_TRIGGER, asserts TLU_BUSY,

---
 rtl/tlu_pkg.sv | 20 ++
 rtl/tlu_sync_ff.sv | 26 ++
 rtl/tlu_dut_rx.sv | 176 +++++++++++++++++
 tb/tb_tlu_dut_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tlu_pkg.sv
// Shared TLU handshake definitions, used by the DUT-side receiver and the
// master-side transmitter.
package tlu_pkg;

   // Trigger ID width: one TLU_CLOCK rising edge per ID bit.
   localparam int TLU_ID_BITS = 15;

   // Handshake states. The encodings are fixed so both ends of the link
   // and any debug tooling decode them the same way.
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_QUAL     = 3'd1,
      ST_ACK      = 3'd2,
      ST_SHIFT_HI = 3'd3,
      ST_SHIFT_LO = 3'd4,
      ST_DONE     = 3'd5,
      ST_WAIT_LOW = 3'd6
   } tlu_state_t;

endpackage

// File: rtl/tlu_sync_ff.sv
// Two-stage synchronizer for the asynchronous TLU_TRIGGER input.
// Both stages reset to 0 so a reset never looks like a pending trigger.
module tlu_sync_ff (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Capture the async input, then let the first stage settle for one cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/tlu_dut_rx.sv
// DUT-side TLU trigger receiver. Qualifies a trigger, raises BUSY, clocks
// in the trigger ID (LSB first) and hands it to readout with a one-cycle
// valid pulse. BUSY and TLU_CLOCK are registered from the next state so
// the pads never see a combinational path.
//
// Handshake (master <-> this block): the master raises TLU_TRIGGER; once
// BUSY is high the master drops TLU_TRIGGER (start bit 0) and presents
// ID bit k after the (k+1)-th TLU_CLOCK rise; this block samples each bit
// at the end of the following TLU_CLOCK low phase. BUSY stays high until
// readout releases DUT_VETO and the master has returned TLU_TRIGGER low.
module tlu_dut_rx
   import tlu_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int ID_BITS = TLU_ID_BITS
) (
   input  logic               SYS_CLK,
   input  logic               SYS_RST_N,
   input  logic               ENABLE,
   input  logic [3:0]         CONF_TRIG_MIN,
   input  logic [15:0]        CONF_TIME_OUT,
   input  logic               DUT_VETO,
   input  logic               TLU_TRIGGER,
   output logic               TLU_BUSY,
   output logic               TLU_CLOCK,
   output logic [ID_BITS-1:0] TRIG_ID,
   output logic               TRIG_ID_VALID,
   output logic [31:0]        TRIG_CNT,
   output logic               ERR_TIME_OUT,
   output logic [2:0]         DBG_STATE
);

   localparam int HC_W = $clog2(CLK_DIV);
   localparam int BC_W = $clog2(ID_BITS);

   tlu_state_t         r_state;
   tlu_state_t         w_state_nxt;
   logic               w_trig;
   logic               w_busy_nxt;
   logic               w_half_done;
   logic               w_sample;
   logic               w_capture;
   logic [4:0]         w_qual_min;
   logic [4:0]         w_qual_inc;
   logic [ID_BITS-1:0] w_sr_nxt;

   logic [3:0]         r_qual_cnt;
   logic [15:0]        r_tmo_cnt;
   logic [HC_W-1:0]    r_half_cnt;
   logic [BC_W-1:0]    r_bit_cnt;
   logic [ID_BITS-2:0] r_sr;
   logic               r_busy;
   logic               r_clock;
   logic [ID_BITS-1:0] r_trig_id;
   logic               r_valid;
   logic [31:0]        r_trig_cnt;
   logic               r_err;

   tlu_sync_ff u_sync (
      .i_clk   (SYS_CLK),
      .i_rst_n (SYS_RST_N),
      .i_d     (TLU_TRIGGER),
      .o_q     (w_trig)
   );

   // A qualification length of 0 behaves as 1.
   assign w_qual_min  = (CONF_TRIG_MIN == 4'd0) ? 5'd1 : {1'b0, CONF_TRIG_MIN};
   assign w_qual_inc  = {1'b0, r_qual_cnt} + 5'd1;
   assign w_half_done = (r_half_cnt == '0);
   assign w_sample    = (r_state == ST_SHIFT_LO) && w_half_done;
   assign w_capture   = w_sample && (r_bit_cnt == BC_W'(ID_BITS - 1));
   // Shift right so the first sampled bit ends up at bit 0; the last sample
   // completes the word directly from the synced input.
   assign w_sr_nxt    = {w_trig, r_sr};

   // State register.
   always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and the BUSY level that follows from it.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (ENABLE && w_trig) w_state_nxt = ST_QUAL;
         end
         ST_QUAL: begin
            if (!w_trig)                     w_state_nxt = ST_IDLE;
            else if (w_qual_inc >= w_qual_min) w_state_nxt = ST_ACK;
         end
         ST_ACK: begin
            if (!w_trig)                  w_state_nxt = ST_SHIFT_HI;
            else if (r_tmo_cnt == 16'd0) w_state_nxt = ST_WAIT_LOW;
         end
         ST_SHIFT_HI: begin
            if (w_half_done) w_state_nxt = ST_SHIFT_LO;
         end
         ST_SHIFT_LO: begin
            if (w_capture)     w_state_nxt = ST_DONE;
            else if (w_sample) w_state_nxt = ST_SHIFT_HI;
         end
         ST_DONE: begin
            if (!DUT_VETO) w_state_nxt = ST_WAIT_LOW;
         end
         ST_WAIT_LOW: begin
            if (!w_trig) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      // Before the handshake is acknowledged BUSY only reflects ENABLE,
      // so a rejected glitch never shows up at the master.
      w_busy_nxt = 1'b1;
      if (w_state_nxt == ST_IDLE || w_state_nxt == ST_QUAL) w_busy_nxt = !ENABLE;
   end

   // Counters, shift register, pad registers and readout outputs.
   always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
         r_qual_cnt <= '0;
         r_tmo_cnt  <= '0;
         r_half_cnt <= '0;
         r_bit_cnt  <= '0;
         r_sr       <= '0;
         r_busy     <= 1'b1;
         r_clock    <= 1'b0;
         r_trig_id  <= '0;
         r_valid    <= 1'b0;
         r_trig_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         r_busy  <= w_busy_nxt;
         r_clock <= (w_state_nxt == ST_SHIFT_HI);

         if (r_state == ST_IDLE)                   r_qual_cnt <= '0;
         else if (r_state == ST_QUAL && w_trig)    r_qual_cnt <= w_qual_inc[3:0];

         // Timeout loads on ACK entry so later CONF_TIME_OUT edits wait for the next handshake.
         if (w_state_nxt == ST_ACK && r_state != ST_ACK) r_tmo_cnt <= CONF_TIME_OUT;
         else if (r_state == ST_ACK && r_tmo_cnt != 16'd0) r_tmo_cnt <= r_tmo_cnt - 16'd1;

         if (r_state == ST_ACK && w_trig && r_tmo_cnt == 16'd0) r_err <= 1'b1;

         // Every entry into a shift phase restarts the half-period count.
         if ((w_state_nxt == ST_SHIFT_HI || w_state_nxt == ST_SHIFT_LO) && w_state_nxt != r_state)
            r_half_cnt <= HC_W'(CLK_DIV - 1);
         else if (!w_half_done)
            r_half_cnt <= r_half_cnt - 1'b1;

         if (r_state == ST_ACK) r_bit_cnt <= '0;
         else if (w_sample)     r_bit_cnt <= r_bit_cnt + 1'b1;

         if (w_sample) r_sr <= w_sr_nxt[ID_BITS-1:1];

         r_valid <= w_capture;
         if (w_capture) begin
            r_trig_id  <= w_sr_nxt;
            r_trig_cnt <= r_trig_cnt + 32'd1;
         end
      end
   end

   assign TLU_BUSY      = r_busy;
   assign TLU_CLOCK     = r_clock;
   assign TRIG_ID       = r_trig_id;
   assign TRIG_ID_VALID = r_valid;
   assign TRIG_CNT      = r_trig_cnt;
   assign ERR_TIME_OUT  = r_err;
   assign DBG_STATE     = r_state;

endmodule

// File: tb/tb_tlu_dut_rx.sv
// Bench for tlu_dut_rx: behavioural TLU master shifting {ID,0} right on each
// TLU_CLOCK rise, a monitor that scores every TRIG_ID_VALID against the
// queue of IDs sent, and directed scenarios for glitch, timeout, veto and reset.
module tb_tlu_dut_rx;

   localparam int ID_BITS = 15;

   logic               SYS_CLK;
   logic               SYS_RST_N;
   logic               ENABLE;
   logic [3:0]         CONF_TRIG_MIN;
   logic [15:0]        CONF_TIME_OUT;
   logic               DUT_VETO;
   logic               TLU_TRIGGER;
   logic               TLU_BUSY;
   logic               TLU_CLOCK;
   logic [ID_BITS-1:0] TRIG_ID;
   logic               TRIG_ID_VALID;
   logic [31:0]        TRIG_CNT;
   logic               ERR_TIME_OUT;
   logic [2:0]         DBG_STATE;

   int                 n_checks = 0;
   int                 n_fail   = 0;
   int                 rise_cnt = 0;
   int                 valid_cnt = 0;
   logic [31:0]        exp_cnt = 0;
   logic               mon_prev_clk = 1'b0;
   logic [ID_BITS-1:0] exp_q[$];
   logic [ID_BITS-1:0] exp_id;

   tlu_dut_rx #(.CLK_DIV(4), .ID_BITS(ID_BITS)) dut (
      .SYS_CLK       (SYS_CLK),
      .SYS_RST_N     (SYS_RST_N),
      .ENABLE        (ENABLE),
      .CONF_TRIG_MIN (CONF_TRIG_MIN),
      .CONF_TIME_OUT (CONF_TIME_OUT),
      .DUT_VETO      (DUT_VETO),
      .TLU_TRIGGER   (TLU_TRIGGER),
      .TLU_BUSY      (TLU_BUSY),
      .TLU_CLOCK     (TLU_CLOCK),
      .TRIG_ID       (TRIG_ID),
      .TRIG_ID_VALID (TRIG_ID_VALID),
      .TRIG_CNT      (TRIG_CNT),
      .ERR_TIME_OUT  (ERR_TIME_OUT),
      .DBG_STATE     (DBG_STATE)
   );

   // Clock: posedge at 5, 15, ...; bench samples and drives on negedge.
   initial SYS_CLK = 1'b0;
   always #5 SYS_CLK = ~SYS_CLK;

   // Overall time limit.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected TB_RESULT before limit");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Monitor: count TLU_CLOCK rises, score every ID handed to readout.
   always @(negedge SYS_CLK) begin
      if (TLU_CLOCK && !mon_prev_clk) rise_cnt++;
      mon_prev_clk = TLU_CLOCK;
      if (TRIG_ID_VALID) begin
         valid_cnt++;
         exp_cnt++;
         check_eq("exp_q_pending", exp_q.size(), 1);
         if (exp_q.size() > 0) begin
            exp_id = exp_q.pop_front();
            check_eq("trig_id", TRIG_ID, exp_id);
         end
         check_eq("trig_cnt", TRIG_CNT, exp_cnt);
      end
   end

   task automatic wait_busy(input logic val, input int budget, input string tag);
      int c = 0;
      while (TLU_BUSY !== val && c < budget) begin
         @(negedge SYS_CLK);
         c++;
      end
      check_eq(tag, TLU_BUSY, val);
   endtask

   // Master driver. abort_rises>0 pulls reset after that many TLU_CLOCK rises;
   // veto_cycles>0 holds DUT_VETO for that many cycles after the ID arrives.
   task automatic send_id(input logic [ID_BITS-1:0] id, input int abort_rises, input int veto_cycles);
      logic [ID_BITS:0] m;
      int               r0;
      int               v0;
      int               n;
      logic             prev;
      logic             got;
      wait_busy(1'b0, 100, "busy_low_before");
      m  = {id, 1'b0};
      r0 = rise_cnt;
      v0 = valid_cnt;
      if (abort_rises == 0) exp_q.push_back(id);
      if (veto_cycles > 0) DUT_VETO = 1'b1;
      TLU_TRIGGER = 1'b1;
      wait_busy(1'b1, 50, "busy_ack");
      TLU_TRIGGER = m[0];
      n    = 0;
      prev = TLU_CLOCK;
      got  = 1'b0;
      for (int c = 0; c < 2000 && !got; c++) begin
         @(negedge SYS_CLK);
         if (TLU_CLOCK && !prev) begin
            m = m >> 1;
            TLU_TRIGGER = m[0];
            n++;
         end
         prev = TLU_CLOCK;
         if (TRIG_ID_VALID) got = 1'b1;
         if (abort_rises > 0 && n == abort_rises) break;
      end
      if (abort_rises > 0) begin
         // Reset lands mid-cycle while TLU_CLOCK is high.
         #1 SYS_RST_N = 1'b0;
         #1;
         check_eq("rst_busy", TLU_BUSY, 1);
         check_eq("rst_clock", TLU_CLOCK, 0);
         check_eq("rst_valid", TRIG_ID_VALID, 0);
         check_eq("rst_id", TRIG_ID, 0);
         check_eq("rst_cnt", TRIG_CNT, 0);
         check_eq("rst_err", ERR_TIME_OUT, 0);
         check_eq("rst_state", DBG_STATE, 0);
         exp_cnt = 0;
         TLU_TRIGGER = 1'b0;
         repeat (3) @(negedge SYS_CLK);
         SYS_RST_N = 1'b1;
         return;
      end
      check_eq("valid_seen", got, 1);
      TLU_TRIGGER = 1'b0;
      if (veto_cycles > 0) begin
         repeat (veto_cycles) @(negedge SYS_CLK);
         check_eq("busy_veto_held", TLU_BUSY, 1);
         DUT_VETO = 1'b0;
         repeat (3) @(negedge SYS_CLK);
         check_eq("busy_veto_rel", TLU_BUSY, 0);
      end
      repeat (2) @(negedge SYS_CLK);
      check_eq("clk_rises", rise_cnt - r0, ID_BITS);
      check_eq("valid_pulses", valid_cnt - v0, 1);
      check_eq("clk_ends_low", TLU_CLOCK, 0);
   endtask

   initial begin
      int r0;
      int busy_hi;
      logic [ID_BITS-1:0] ids [3];
      ids[0] = 15'h0000;
      ids[1] = 15'h7FFF;
      ids[2] = 15'h0001;

      SYS_RST_N     = 1'b0;
      ENABLE        = 1'b0;
      CONF_TRIG_MIN = 4'd2;
      CONF_TIME_OUT = 16'd1000;
      DUT_VETO      = 1'b0;
      TLU_TRIGGER   = 1'b0;

      // Reset values.
      repeat (2) @(negedge SYS_CLK);
      check_eq("reset_busy", TLU_BUSY, 1);
      check_eq("reset_clock", TLU_CLOCK, 0);
      check_eq("reset_id", TRIG_ID, 0);
      check_eq("reset_valid", TRIG_ID_VALID, 0);
      check_eq("reset_cnt", TRIG_CNT, 0);
      check_eq("reset_err", ERR_TIME_OUT, 0);
      check_eq("reset_state", DBG_STATE, 0);
      SYS_RST_N = 1'b1;

      // Disabled: BUSY stays high; enabling drops it.
      repeat (3) @(negedge SYS_CLK);
      check_eq("busy_disabled", TLU_BUSY, 1);
      ENABLE = 1'b1;
      repeat (2) @(negedge SYS_CLK);
      check_eq("busy_enabled", TLU_BUSY, 0);

      // Single handshake.
      send_id(15'h5A3C, 0, 0);
      check_eq("t1_id_held", TRIG_ID, 15'h5A3C);
      check_eq("t1_cnt", TRIG_CNT, 1);

      // Back-to-back all-zero, all-one, single-LSB IDs.
      for (int i = 0; i < 3; i++) send_id(ids[i], 0, 0);
      wait_busy(1'b0, 20, "t2_busy_low");
      check_eq("t2_cnt", TRIG_CNT, 4);
      check_eq("t2_id_held", TRIG_ID, 15'h0001);

      // One-cycle glitch with a 3-cycle qualification window.
      CONF_TRIG_MIN = 4'd3;
      repeat (4) @(negedge SYS_CLK);
      r0 = rise_cnt;
      TLU_TRIGGER = 1'b1;
      @(negedge SYS_CLK);
      TLU_TRIGGER = 1'b0;
      busy_hi = 0;
      repeat (20) begin
         @(negedge SYS_CLK);
         if (TLU_BUSY) busy_hi++;
      end
      check_eq("t3_no_busy", busy_hi, 0);
      check_eq("t3_no_clock", rise_cnt - r0, 0);
      check_eq("t3_cnt", TRIG_CNT, 4);
      check_eq("t3_state", DBG_STATE, 0);
      CONF_TRIG_MIN = 4'd2;

      // Master never releases TRIGGER: timeout after 20 counted cycles.
      CONF_TIME_OUT = 16'd20;
      r0 = rise_cnt;
      TLU_TRIGGER = 1'b1;
      wait_busy(1'b1, 50, "t4_busy_ack");
      repeat (15) @(negedge SYS_CLK);
      check_eq("t4_err_early", ERR_TIME_OUT, 0);
      repeat (10) @(negedge SYS_CLK);
      check_eq("t4_err_set", ERR_TIME_OUT, 1);
      check_eq("t4_busy_held", TLU_BUSY, 1);
      TLU_TRIGGER = 1'b0;
      wait_busy(1'b0, 20, "t4_busy_release");
      check_eq("t4_err_sticky", ERR_TIME_OUT, 1);
      check_eq("t4_cnt", TRIG_CNT, 4);
      check_eq("t4_no_clock", rise_cnt - r0, 0);
      CONF_TIME_OUT = 16'd1000;

      // Readout veto for 100 cycles after the ID arrives.
      send_id(15'h1234, 0, 100);
      check_eq("t5_cnt", TRIG_CNT, 5);

      // Reset mid-shift at bit 7, then a clean handshake.
      send_id(15'h3FAB, 8, 0);
      send_id(15'h2B6D, 0, 0);
      check_eq("t6_cnt", TRIG_CNT, 1);
      check_eq("t6_id", TRIG_ID, 15'h2B6D);
      check_eq("exp_q_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
